// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM: registered 1-cycle read that holds while re=0,
// with optional write-to-read bypass when both ports hit the same address.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter bit ENABLE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= din;
    if (re) begin
      // Same-cycle write to the address being read returns the new word.
      if (ENABLE_BYPASS && we && (waddr == raddr))
        rdata <= din;
      else
        rdata <= mem[raddr];
    end
  end

  assign dout = rdata;

endmodule

// File: rtl/mor1kx_fwft_fifo.sv
// First-word-fall-through FIFO; push-to-visible latency 1 cycle, the RAM read port is the head.
// wr_ready = !full (no pass-through when full); rd_valid decoded from the registered count.
module mor1kx_fwft_fifo #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] ONE_COUNT  = {{DEPTH_WIDTH{1'b0}}, 1'b1};

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH:0]   count_q;
  logic                   push;
  logic                   pop;
  logic                   ram_we;
  logic                   ram_re;
  logic [DEPTH_WIDTH-1:0] ram_raddr;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign count    = count_q;

  assign push   = wr_valid & wr_ready;
  assign pop    = rd_valid & rd_ready;
  assign ram_we = push & !flush & !rst;

  // The head stays parked on the RAM output; only refetch when it must change.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = rd_ptr;
    if (empty && push) begin
      ram_re    = 1'b1;
      ram_raddr = wr_ptr;
    end else if (pop && (count_q > ONE_COUNT)) begin
      ram_re    = 1'b1;
      ram_raddr = rd_ptr + 1'b1;
    end else if (pop && (count_q == ONE_COUNT) && push) begin
      ram_re    = 1'b1;
      ram_raddr = rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1'b1)
  ) u_ram (
    .clk   (clk),
    .raddr (ram_raddr),
    .re    (ram_re),
    .waddr (wr_ptr),
    .we    (ram_we),
    .din   (wr_data),
    .dout  (rd_data)
  );

  assert property (@(posedge clk) disable iff (rst) count_q <= FULL_COUNT);
  assert property (@(posedge clk) disable iff (rst) !(push && full));
  assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule
